// File: rtl/adc_capture_accum.sv
// Per-channel ADC capture: sums 2^S triggered captures of N beats into an on-chip
// buffer, then streams the shifted averages as 32-bit words. Optional tlast: ADC_CAPTURE_TLAST_EN.
module adc_capture_accum #(
  parameter int SAMPLE_W         = 16,
  parameter int SAMPLES_PER_BEAT = 8,
  parameter int MAX_CYCLES       = 64,
  parameter int CFG_W            = 32,
  parameter int MAX_SHIFT        = 8,
  parameter int ACC_W            = SAMPLE_W + MAX_SHIFT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 trigger,
  input  logic [CFG_W-1:0]                     run_cycles,
  input  logic [CFG_W-1:0]                     shift_val,
  input  logic [SAMPLE_W*SAMPLES_PER_BEAT-1:0] s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 readout_enable,
  output logic [2*SAMPLE_W-1:0]                m_axis_tdata,
  output logic                                 m_axis_tvalid,
`ifdef ADC_CAPTURE_TLAST_EN
  output logic                                 m_axis_tlast,
`endif
  input  logic                                 m_axis_tready,
  output logic                                 busy,
  output logic                                 done
);

  localparam int WPB       = SAMPLES_PER_BEAT / 2;
  localparam int SEL_W     = $clog2(WPB);
  localparam int BEAT_W    = $clog2(MAX_CYCLES);
  localparam int N_W       = BEAT_W + 1;
  localparam int WORD_W    = N_W + SEL_W;
  localparam int S_W       = $clog2(MAX_SHIFT + 1);
  localparam int TRIG_W    = MAX_SHIFT + 1;
  localparam int BEAT_BITS = SAMPLES_PER_BEAT * ACC_W;
  localparam int WORD_BITS = 2 * SAMPLE_W;

  typedef enum logic [2:0] {IDLE, CAPTURE, WAIT_TRIG, READY, READOUT} state_t;

  state_t                state_q, state_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [TRIG_W-1:0]     trig_cnt_q, trig_cnt_d;
  logic [WORD_W-1:0]     fetch_cnt_q, fetch_cnt_d;
  logic [WORD_W-1:0]     out_cnt_q, out_cnt_d;
  logic                  p1_valid_q, p1_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [WORD_BITS-1:0]  skid_data_q, skid_data_d;
  logic                  tvalid_q, tvalid_d;
  logic [WORD_BITS-1:0]  tdata_q, tdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  trig_prev_q;
  logic                  tready_q;
`ifdef ADC_CAPTURE_TLAST_EN
  logic                  tlast_q, tlast_d;
`endif

  logic [BEAT_BITS-1:0]  acc_mem [MAX_CYCLES];
  logic [BEAT_BITS-1:0]  acc_cur;
  logic [BEAT_BITS-1:0]  acc_wr_data;
  logic [BEAT_BITS-1:0]  acc_rd_q;
  logic [SEL_W-1:0]      rd_sel_q;
  logic [WORD_BITS-1:0]  rd_word;
  logic                  acc_wr_en;
  logic                  rd_issue;

  logic                  trig_edge;
  logic                  pop;
  logic [1:0]            occ;
  logic [N_W-1:0]        n_clamp;
  logic [S_W-1:0]        s_clamp;
  logic [WORD_W-1:0]     total_words;
  logic [TRIG_W-1:0]     trig_last;
  logic                  last_beat;
  logic [BEAT_W-1:0]     fetch_beat;

  function automatic logic [SAMPLE_W-1:0] avg_of(input logic signed [ACC_W-1:0] acc,
                                                 input logic [S_W-1:0] sh);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> sh;
    return shifted[SAMPLE_W-1:0];
  endfunction

  assign trig_edge   = trigger && !trig_prev_q;
  assign pop         = tvalid_q && m_axis_tready;
  assign occ         = {1'b0, p1_valid_q} + {1'b0, tvalid_q} + {1'b0, skid_valid_q};
  assign n_clamp     = (run_cycles > CFG_W'(MAX_CYCLES)) ? N_W'(MAX_CYCLES) : N_W'(run_cycles);
  assign s_clamp     = (shift_val > CFG_W'(MAX_SHIFT)) ? S_W'(MAX_SHIFT) : S_W'(shift_val);
  assign total_words = {n_q, {SEL_W{1'b0}}};
  assign trig_last   = TRIG_W'((1 << s_q) - 1);
  assign last_beat   = ({1'b0, beat_cnt_q} == (n_q - N_W'(1)));
  assign fetch_beat  = fetch_cnt_q[SEL_W +: BEAT_W];
  assign acc_cur     = acc_mem[beat_cnt_q];

  // First trigger of a run overwrites the buffer entry; later triggers add to it.
  always_comb begin
    acc_wr_data = '0;
    for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
      acc_wr_data[i*ACC_W +: ACC_W] =
        ((trig_cnt_q == '0) ? ACC_W'(0) : acc_cur[i*ACC_W +: ACC_W]) +
        {{MAX_SHIFT{s_axis_tdata[i*SAMPLE_W + SAMPLE_W-1]}}, s_axis_tdata[i*SAMPLE_W +: SAMPLE_W]};
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 2; k++) begin
      rd_word[k*SAMPLE_W +: SAMPLE_W] =
        avg_of(acc_rd_q[(2*int'(rd_sel_q) + k)*ACC_W +: ACC_W], s_q);
    end
  end

  // NOTE: the buffer and its read register have no reset; every entry is overwritten
  // by the first trigger of a run, and read data is only used behind a valid flag.
  always_ff @(posedge clk) begin
    if (acc_wr_en) acc_mem[beat_cnt_q] <= acc_wr_data;
    if (rd_issue) begin
      acc_rd_q <= acc_mem[fetch_beat];
      rd_sel_q <= fetch_cnt_q[SEL_W-1:0];
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    s_d          = s_q;
    beat_cnt_d   = beat_cnt_q;
    trig_cnt_d   = trig_cnt_q;
    fetch_cnt_d  = fetch_cnt_q;
    out_cnt_d    = out_cnt_q;
    p1_valid_d   = 1'b0;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    acc_wr_en    = 1'b0;
    rd_issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig_edge) begin
          n_d        = n_clamp;
          s_d        = s_clamp;
          trig_cnt_d = '0;
          beat_cnt_d = '0;
          state_d    = (n_clamp == '0) ? READY : CAPTURE;
        end
      end
      CAPTURE: begin
        if (s_axis_tvalid) begin
          acc_wr_en = 1'b1;
          if (last_beat) begin
            if (trig_cnt_q == trig_last) begin
              state_d = READY;
            end else begin
              trig_cnt_d = trig_cnt_q + TRIG_W'(1);
              beat_cnt_d = '0;
              state_d    = WAIT_TRIG;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      WAIT_TRIG: begin
        if (trig_edge) state_d = CAPTURE;
      end
      READY: begin
        if (readout_enable) begin
          fetch_cnt_d = '0;
          out_cnt_d   = '0;
          state_d     = (n_q == '0) ? IDLE : READOUT;
        end
      end
      READOUT: begin
        // Read ahead only while the output and skid registers can absorb the result.
        rd_issue   = readout_enable && (fetch_cnt_q != total_words) &&
                     ((occ - {1'b0, pop}) < 2'd2);
        p1_valid_d = rd_issue;
        if (rd_issue) fetch_cnt_d = fetch_cnt_q + WORD_W'(1);

        if (!tvalid_q || pop) begin
          if (skid_valid_q) begin
            tvalid_d     = 1'b1;
            tdata_d      = skid_data_q;
            skid_valid_d = p1_valid_q;
            skid_data_d  = rd_word;
          end else begin
            tvalid_d = p1_valid_q;
            if (p1_valid_q) tdata_d = rd_word;
          end
        end else if (p1_valid_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = rd_word;
        end

        if (pop) out_cnt_d = out_cnt_q + WORD_W'(1);

        if (pop && (out_cnt_q == total_words - WORD_W'(1))) begin
          state_d      = IDLE;
          tvalid_d     = 1'b0;
          skid_valid_d = 1'b0;
          p1_valid_d   = 1'b0;
        end else if (!readout_enable) begin
          state_d      = READY;
          tvalid_d     = 1'b0;
          skid_valid_d = 1'b0;
          p1_valid_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE) || (state_d == WAIT_TRIG);
    done_d = (state_d == READY) || (state_d == READOUT);
`ifdef ADC_CAPTURE_TLAST_EN
    tlast_d = tvalid_d && (out_cnt_d == total_words - WORD_W'(1));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      s_q          <= '0;
      beat_cnt_q   <= '0;
      trig_cnt_q   <= '0;
      fetch_cnt_q  <= '0;
      out_cnt_q    <= '0;
      p1_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_prev_q  <= 1'b0;
      tready_q     <= 1'b0;
`ifdef ADC_CAPTURE_TLAST_EN
      tlast_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      s_q          <= s_d;
      beat_cnt_q   <= beat_cnt_d;
      trig_cnt_q   <= trig_cnt_d;
      fetch_cnt_q  <= fetch_cnt_d;
      out_cnt_q    <= out_cnt_d;
      p1_valid_q   <= p1_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trig_prev_q  <= trigger;
      tready_q     <= 1'b1;
`ifdef ADC_CAPTURE_TLAST_EN
      tlast_q      <= tlast_d;
`endif
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef ADC_CAPTURE_TLAST_EN
  assign m_axis_tlast  = tlast_q;
`endif

endmodule

// File: tb/tb_adc_capture_accum.sv
// Randomised bench for adc_capture_accum: a plain-arithmetic accumulation model feeds
// a scoreboard queue; a negedge monitor pops and compares every readout handshake.
module tb_adc_capture_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         trigger;
  logic [31:0]  run_cycles;
  logic [31:0]  shift_val;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         readout_enable;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         busy;
  logic         done;
`ifdef ADC_CAPTURE_TLAST_EN
  logic         m_axis_tlast;
`endif

  adc_capture_accum dut (
    .clk            (clk),
    .rst            (rst),
    .trigger        (trigger),
    .run_cycles     (run_cycles),
    .shift_val      (shift_val),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .readout_enable (readout_enable),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
`ifdef ADC_CAPTURE_TLAST_EN
    .m_axis_tlast   (m_axis_tlast),
`endif
    .m_axis_tready  (m_axis_tready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc_g = 0;
  int          hs_cnt = 0;
  int          first_hs_cyc = 0;
  int          last_hs_cyc = 0;
  logic [31:0] sb[$];
  int          acc_m [64][8];
  bit          hold_chk = 1'b0;
  logic [31:0] held_data = '0;

  always @(posedge clk) cyc_g++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled mid-cycle, so tvalid&&tready here means a handshake at the next edge.
  always @(negedge clk) begin
    if (rst && hold_chk && readout_enable) begin
      check("stall_hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
      check("stall_hold_data", m_axis_tdata, held_data);
    end
    if (rst && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected no word", m_axis_tdata);
      end else begin
`ifdef ADC_CAPTURE_TLAST_EN
        check("tlast", {31'b0, m_axis_tlast}, (sb.size() == 1) ? 32'd1 : 32'd0);
`endif
        check($sformatf("word%0d", hs_cnt), m_axis_tdata, sb.pop_front());
      end
      if (hs_cnt == 0) first_hs_cyc = cyc_g;
      last_hs_cyc = cyc_g;
      hs_cnt++;
    end
    hold_chk  = rst && m_axis_tvalid && !m_axis_tready && readout_enable;
    held_data = m_axis_tdata;
  end

  function automatic logic [15:0] gen_sample(input int mode, input int t, input int b, input int l);
    case (mode)
      0:       return 16'(32'h1000 * (l + 1));
      1:       return (((t + b) % 2) == 0) ? 16'h0010 : 16'h0030;
      2:       return (t == 0) ? 16'hFFFE : 16'hFFFC;
      4:       return ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_cfg(input int n_raw, input int s_raw);
    run_cycles = n_raw;
    shift_val  = s_raw;
  endtask

  // Runs 2^s_eff triggered captures of n_eff beats and accumulates them in the model.
  task automatic capture_all(input int n_eff, input int s_eff, input int mode,
                             input bit glitch, input int hold);
    logic [15:0] smp;
    for (int t = 0; t < (1 << s_eff); t++) begin
      tick();
      trigger = 1'b1;
      tick();
      if (t == 0) begin
        run_cycles = $urandom;
        shift_val  = $urandom;
      end
      if (!(hold > 0 && t == 0)) trigger = 1'b0;
      for (int b = 0; b < n_eff; b++) begin
        if (mode >= 3 && $urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
          tick();
        end
        if (glitch && b == n_eff / 2) trigger = 1'b1;
        for (int l = 0; l < 8; l++) begin
          smp = gen_sample(mode, t, b, l);
          s_axis_tdata[16*l +: 16] = smp;
          acc_m[b][l] = ((t == 0) ? 0 : acc_m[b][l]) + int'($signed(smp));
        end
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        if (glitch) trigger = 1'b0;
      end
      if (hold > 0 && t == 0) begin
        // Trigger still high: beats offered now must not start another capture.
        for (int h = 0; h < hold; h++) begin
          s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
          s_axis_tvalid = 1'b1;
          tick();
        end
        s_axis_tvalid = 1'b0;
        check("hold_wait_state", {30'b0, busy, done}, 32'b10);
        trigger = 1'b0;
      end
      if (t < (1 << s_eff) - 1)
        check("busy_between_triggers", {30'b0, busy, done}, 32'b10);
    end
    check("done_after_capture", {29'b0, busy, done, m_axis_tvalid}, 32'b010);
  endtask

  task automatic readout(input int n_eff, input int s_eff, input int mode, input int abort_at);
    int          cyc = 0;
    int          stall = 0;
    int          last_seen = 0;
    bit          aborted = 1'b0;
    logic [15:0] lo, hi;
    sb.delete();
    for (int k = 0; k < 4 * n_eff; k++) begin
      lo = 16'(acc_m[k/4][2*(k%4)] >>> s_eff);
      hi = 16'(acc_m[k/4][2*(k%4)+1] >>> s_eff);
      sb.push_back({hi, lo});
    end
    hs_cnt         = 0;
    readout_enable = 1'b1;
    m_axis_tready  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    while (sb.size() > 0 && cyc < 4000) begin
      tick();
      cyc++;
      if (abort_at > 0 && hs_cnt == abort_at) begin
        readout_enable = 1'b0;
        m_axis_tready  = 1'b0;
        aborted        = 1'b1;
        break;
      end
      case (mode)
        1: begin
          if (hs_cnt != last_seen) begin
            last_seen = hs_cnt;
            if (hs_cnt % 5 == 0) stall = 20;
          end
          if (stall > 0) begin
            m_axis_tready = 1'b0;
            stall--;
          end else begin
            m_axis_tready = 1'b1;
          end
        end
        2:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b1;
      endcase
    end
    if (aborted) begin
      repeat (3) tick();
      check("abort_back_to_ready", {29'b0, m_axis_tvalid, busy, done}, 32'b001);
    end else begin
      if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL readout_timeout: got %0d words left expected 0", sb.size());
      end
      check("words_received", hs_cnt, 4 * n_eff);
      check("end_state_idle", {29'b0, m_axis_tvalid, busy, done}, 32'b000);
      if (mode == 0) check("no_gap_span", last_hs_cyc - first_hs_cyc, 4 * n_eff - 1);
    end
    readout_enable = 1'b0;
    m_axis_tready  = 1'b0;
  endtask

  initial begin
    int n_r, s_r;
    rst            = 1'b0;
    trigger        = 1'b0;
    run_cycles     = '0;
    shift_val      = '0;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    readout_enable = 1'b0;
    m_axis_tready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_s_tready", {31'b0, s_axis_tready}, 32'd0);
    check("rst_busy_done", {30'b0, busy, done}, 32'b00);
    rst = 1'b1;
    tick();
    check("s_tready_after_rst", {31'b0, s_axis_tready}, 32'd1);

    // Single capture, constant beat, unstalled readout.
    set_cfg(16, 0);
    capture_all(16, 0, 0, 1'b0, 0);
    readout(16, 0, 0, 0);

    // Averaging of 4 triggers.
    set_cfg(4, 2);
    capture_all(4, 2, 1, 1'b0, 0);
    readout(4, 2, 2, 0);

    // Signed average of negative samples.
    set_cfg(2, 1);
    capture_all(2, 1, 2, 1'b0, 0);
    readout(2, 1, 0, 0);

    // Back-pressure with trigger edges injected during CAPTURE.
    set_cfg(16, 1);
    capture_all(16, 1, 3, 1'b1, 0);
    readout(16, 1, 1, 0);

    // Readout abort after word 10, then a full restart.
    set_cfg(16, 0);
    capture_all(16, 0, 3, 1'b0, 0);
    readout(16, 0, 0, 10);
    readout(16, 0, 0, 0);

    // N=0: done with no words, enable returns to idle.
    set_cfg(0, 3);
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("n0_done", {29'b0, busy, done, m_axis_tvalid}, 32'b010);
    readout_enable = 1'b1;
    m_axis_tready  = 1'b1;
    repeat (5) tick();
    check("n0_back_idle", {29'b0, busy, done, m_axis_tvalid}, 32'b000);
    readout_enable = 1'b0;
    m_axis_tready  = 1'b0;

    // Clamps: run_cycles=100 -> 64 beats; shift_val=20 -> 8 with full-scale samples.
    set_cfg(100, 0);
    capture_all(64, 0, 3, 1'b0, 0);
    readout(64, 0, 2, 0);
    set_cfg(3, 20);
    capture_all(3, 8, 4, 1'b0, 0);
    readout(3, 8, 2, 0);

    // Reset during CAPTURE.
    set_cfg(16, 1);
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int b = 0; b < 5; b++) begin
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tvalid = 1'b1;
      tick();
    end
    check("busy_mid_capture", {30'b0, busy, done}, 32'b10);
    rst = 1'b0;
    #1;
    check("midrst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("midrst_state", {29'b0, busy, done, s_axis_tready}, 32'b000);
    s_axis_tvalid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("after_midrst_idle", {29'b0, busy, done, s_axis_tready}, 32'b001);

    // Trigger held high for 10 cycles counts once.
    set_cfg(3, 1);
    capture_all(3, 1, 3, 1'b0, 10);
    readout(3, 1, 2, 0);

    // Random runs.
    for (int i = 0; i < 3; i++) begin
      n_r = $urandom_range(1, 20);
      s_r = $urandom_range(0, 3);
      set_cfg(n_r, s_r);
      capture_all(n_r, s_r, 3, 1'b0, 0);
      readout(n_r, s_r, 2, 0);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
